dram_port_arbiter: RTL

- Shares the single dram0 peek/poke port between NUM_REQ requesters, e.g. the csr_spi special-command path and the nkmd debug/DMA path.
- Requesters issue one-cycle write or pop strobes with address and data. The arbiter latches each strobe into a per-port pending slot, then grants slots round-robin.
- It issues exactly one downstream transaction at a time and routes the ack and read data back to the originating port.
- A watchdog completes any transaction the DRAM side never acknowledges, so the SPI side cannot hang.

---
 rtl/dram_port_arbiter_if.sv | 28 ++
 rtl/dram_port_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter_if.sv
// Requester-side and DRAM-side bus bundle for dram_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and DRAM model's view.
interface dram_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
) ();
  logic [NUM_REQ*28-1:0] req_addr_i;
  logic [NUM_REQ*32-1:0] req_data_i;
  logic [NUM_REQ-1:0]    req_we_i;
  logic [NUM_REQ-1:0]    req_pop_i;
  logic [31:0]           req_data_o;
  logic [NUM_REQ-1:0]    req_ack_o;
  logic [27:0]           dram0_addr_o;
  logic [31:0]           dram0_data_o;
  logic                  dram0_we_o;
  logic                  dram0_pop_o;
  logic [31:0]           dram0_data_i;
  logic                  dram0_ack_i;

  modport slave (
    input  req_addr_i, req_data_i, req_we_i, req_pop_i, dram0_data_i, dram0_ack_i,
    output req_data_o, req_ack_o, dram0_addr_o, dram0_data_o, dram0_we_o, dram0_pop_o
  );

  modport master (
    output req_addr_i, req_data_i, req_we_i, req_pop_i, dram0_data_i, dram0_ack_i,
    input  req_data_o, req_ack_o, dram0_addr_o, dram0_data_o, dram0_we_o, dram0_pop_o
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one dram0 peek/poke port among NUM_REQ requesters,
// with per-port pending slots, one outstanding transaction and an ack watchdog.
module dram_port_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned TO_W     = 10,
  parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
  input  logic               clk,
  input  logic               rst_n,
  dram_port_arbiter_if.slave bus,
  output logic [NUM_REQ-1:0] overflow_o,
  output logic               timeout_o,
  input  logic               clr_status_i
);

  localparam int unsigned AW    = 28;
  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } slot_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  state_t                  state_q, state_d;
  slot_t [NUM_REQ-1:0]     slot_q, slot_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [TO_W-1:0]         wd_q, wd_d;
  logic [AW-1:0]           daddr_q, daddr_d;
  logic [DW-1:0]           ddata_q, ddata_d;
  logic                    dwe_q, dwe_d;
  logic                    dpop_q, dpop_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      ovf_q, ovf_d;
  logic                    to_q, to_d;

  logic                    pick_vld;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        scan_idx;
  logic                    grant_fire;

  // First valid slot searching upward from last_grant+1 with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_idx = IDX_W'((32'(last_q) + i) % NUM_REQ);
      if (!pick_vld && slot_q[scan_idx].valid) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign grant_fire = (state_q == IDLE) && pick_vld;

  // Pending slots: a strobe refills a slot that is empty or being granted, otherwise it is dropped.
  always_comb begin
    slot_d = slot_q;
    ovf_d  = clr_status_i ? '0 : ovf_q;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (grant_fire && (pick_idx == IDX_W'(n))) begin
        slot_d[n].valid = 1'b0;
      end
      if (bus.req_we_i[n] || bus.req_pop_i[n]) begin
        if (!slot_q[n].valid || (grant_fire && (pick_idx == IDX_W'(n)))) begin
          slot_d[n].valid = 1'b1;
          slot_d[n].we    = bus.req_we_i[n];
          slot_d[n].addr  = bus.req_addr_i[n*AW +: AW];
          slot_d[n].data  = bus.req_data_i[n*DW +: DW];
        end else begin
          ovf_d[n] = 1'b1;
        end
      end
    end
  end

  // Transaction FSM and watchdog; ack beats timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;
    dwe_d   = 1'b0;
    dpop_d  = 1'b0;
    rdata_d = rdata_q;
    ack_d   = '0;
    to_d    = clr_status_i ? 1'b0 : to_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          daddr_d = slot_q[pick_idx].addr;
          ddata_d = slot_q[pick_idx].data;
          dwe_d   = slot_q[pick_idx].we;
          dpop_d  = !slot_q[pick_idx].we;
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE, WAIT_ACK: begin
        wd_d    = TO_W'(wd_q + 1'b1);
        state_d = WAIT_ACK;
        if (bus.dram0_ack_i) begin
          rdata_d         = bus.dram0_data_i;
          ack_d[grant_q]  = 1'b1;
          state_d         = IDLE;
        end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
          rdata_d         = ERR_DATA;
          ack_d[grant_q]  = 1'b1;
          to_d            = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      wd_q    <= '0;
      daddr_q <= '0;
      ddata_q <= '0;
      dwe_q   <= 1'b0;
      dpop_q  <= 1'b0;
      rdata_q <= '0;
      ack_q   <= '0;
      ovf_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
      dwe_q   <= dwe_d;
      dpop_q  <= dpop_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
    end
  end

  assign bus.dram0_addr_o = daddr_q;
  assign bus.dram0_data_o = ddata_q;
  assign bus.dram0_we_o   = dwe_q;
  assign bus.dram0_pop_o  = dpop_q;
  assign bus.req_data_o   = rdata_q;
  assign bus.req_ack_o    = ack_q;
  assign overflow_o       = ovf_q;
  assign timeout_o        = to_q;

endmodule
